// File: rtl/video_sig_gen_pkg.sv
// video_timing_pkg: shared timing constants and types for the video signal
// generator. Holds the 1280x720@60 defaults, the derived line/frame totals,
// the sync start/end indices at those defaults, the FSM state type and small
// helpers that derive the sync window from any parameter set.
package video_timing_pkg;

  localparam int DEF_ACTIVE_H_PIXELS = 1280;
  localparam int DEF_H_FRONT_PORCH   = 110;
  localparam int DEF_H_SYNC_WIDTH    = 40;
  localparam int DEF_H_BACK_PORCH    = 220;
  localparam int DEF_ACTIVE_LINES    = 720;
  localparam int DEF_V_FRONT_PORCH   = 5;
  localparam int DEF_V_SYNC_WIDTH    = 5;
  localparam int DEF_V_BACK_PORCH    = 20;
  localparam int DEF_FPS             = 60;

  localparam int TOTAL_H = DEF_ACTIVE_H_PIXELS + DEF_H_FRONT_PORCH
                         + DEF_H_SYNC_WIDTH + DEF_H_BACK_PORCH;
  localparam int TOTAL_V = DEF_ACTIVE_LINES + DEF_V_FRONT_PORCH
                         + DEF_V_SYNC_WIDTH + DEF_V_BACK_PORCH;

  localparam int H_SYNC_START = DEF_ACTIVE_H_PIXELS + DEF_H_FRONT_PORCH;
  localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC_WIDTH - 1;
  localparam int V_SYNC_START = DEF_ACTIVE_LINES + DEF_V_FRONT_PORCH;
  localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC_WIDTH - 1;

  // Counter widths are fixed by the downstream bus format.
  localparam int H_W = 11;
  localparam int V_W = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } vsg_state_t;

  function automatic int sync_start(input int active, input int front);
    return active + front;
  endfunction

  function automatic int sync_end(input int active, input int front, input int width);
    return active + front + width - 1;
  endfunction

endpackage

// File: rtl/video_sig_gen_if.sv
// video_sig_gen_if: raster position and timing flags produced by
// video_sig_gen. The master modport drives them (the generator); the slave
// modport consumes them (encoders, graphics logic).
//   h_count_out / v_count_out : current pixel / line index
//   h_sync_out / v_sync_out   : active-high syncs
//   active_draw_out           : (h,v) inside the visible region
//   new_frame_out             : one-cycle pulse at start of vertical blanking
//   frame_count_out           : frames modulo FPS (FC_W = $clog2(FPS))
//   preamble_out / guard_out  : only with VSG_DATA_ISLAND_PREAMBLE_EN
interface video_sig_gen_if #(
  parameter int FC_W = 6
);
  logic [10:0]     h_count_out;
  logic [9:0]      v_count_out;
  logic            h_sync_out;
  logic            v_sync_out;
  logic            active_draw_out;
  logic            new_frame_out;
  logic [FC_W-1:0] frame_count_out;
`ifdef VSG_DATA_ISLAND_PREAMBLE_EN
  logic            preamble_out;
  logic            guard_out;
`endif

  modport master (
    output h_count_out, v_count_out, h_sync_out, v_sync_out,
           active_draw_out, new_frame_out, frame_count_out
`ifdef VSG_DATA_ISLAND_PREAMBLE_EN
    , output preamble_out, guard_out
`endif
  );

  modport slave (
    input h_count_out, v_count_out, h_sync_out, v_sync_out,
          active_draw_out, new_frame_out, frame_count_out
`ifdef VSG_DATA_ISLAND_PREAMBLE_EN
    , input preamble_out, guard_out
`endif
  );
endinterface

// File: rtl/video_sig_gen_wrap_counter.sv
// wrap_counter: modulo-MAX up counter.
//   clk_in    : clock
//   rst_in    : synchronous active-high reset, clears the count to 0
//   en_in     : advance by one on this edge
//   count_out : current count, 0..MAX-1
//   wrap_out  : high when enabled and at MAX-1, i.e. this edge returns to 0
module wrap_counter #(
  parameter int MAX = 1650,
  parameter int W   = 11
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         en_in,
  output logic [W-1:0] count_out,
  output logic         wrap_out
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  assign wrap_out = en_in && (count_out == LAST);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_out <= '0;
    end else if (en_in) begin
      count_out <= wrap_out ? '0 : count_out + 1'b1;
    end
  end

endmodule

// File: rtl/video_sig_gen.sv
// video_sig_gen: pixel-clock video timing generator (default 1280x720@60).
// Ports:
//   clk_in : pixel clock
//   rst_in : synchronous active-high reset; outputs read all-zero while held
//   vid    : video_sig_gen_if master - raster position, h/v sync,
//            active_draw, new_frame pulse and frame counter.
// Optional build macro VSG_DATA_ISLAND_PREAMBLE_EN adds preamble_out /
// guard_out on the interface ahead of every line that precedes an active line.
//
// Position counters are the registered h/v outputs directly. The flags are
// registered from a one-edge look-ahead of the counters, so they always
// describe the (h,v) presented on the same cycle.
module video_sig_gen
  import video_timing_pkg::*;
#(
  parameter int ACTIVE_H_PIXELS = DEF_ACTIVE_H_PIXELS,
  parameter int H_FRONT_PORCH   = DEF_H_FRONT_PORCH,
  parameter int H_SYNC_WIDTH    = DEF_H_SYNC_WIDTH,
  parameter int H_BACK_PORCH    = DEF_H_BACK_PORCH,
  parameter int ACTIVE_LINES    = DEF_ACTIVE_LINES,
  parameter int V_FRONT_PORCH   = DEF_V_FRONT_PORCH,
  parameter int V_SYNC_WIDTH    = DEF_V_SYNC_WIDTH,
  parameter int V_BACK_PORCH    = DEF_V_BACK_PORCH,
  parameter int FPS             = DEF_FPS
) (
  input  logic             clk_in,
  input  logic             rst_in,
  video_sig_gen_if.master  vid
);

  localparam int TH   = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
  localparam int TV   = ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;
  localparam int FC_W = $clog2(FPS);

  localparam logic [H_W-1:0] H_ACT   = H_W'(ACTIVE_H_PIXELS);
  localparam logic [H_W-1:0] HS_LO   = H_W'(sync_start(ACTIVE_H_PIXELS, H_FRONT_PORCH));
  localparam logic [H_W-1:0] HS_HI   = H_W'(sync_end(ACTIVE_H_PIXELS, H_FRONT_PORCH, H_SYNC_WIDTH));
  localparam logic [V_W-1:0] V_ACT   = V_W'(ACTIVE_LINES);
  localparam logic [V_W-1:0] VS_LO   = V_W'(sync_start(ACTIVE_LINES, V_FRONT_PORCH));
  localparam logic [V_W-1:0] VS_HI   = V_W'(sync_end(ACTIVE_LINES, V_FRONT_PORCH, V_SYNC_WIDTH));
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FPS - 1);

  if (TH > 2048) begin : g_h_too_wide
    $error("video_sig_gen: TOTAL_H %0d exceeds 11-bit counter", TH);
  end
  if (TV > 1024) begin : g_v_too_tall
    $error("video_sig_gen: TOTAL_V %0d exceeds 10-bit counter", TV);
  end

  vsg_state_t state, state_nxt;
  logic       run;

  // FSM: state register
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state; leaving IDLE is only blocked by reset
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    run = (state == RUN);
  end

  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic           h_wrap, v_wrap;

  // The counter holds 0 through the release edge, so (0,0) is shown first.
  wrap_counter #(.MAX(TH), .W(H_W)) u_h_cnt (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .en_in    (run),
    .count_out(h_cnt),
    .wrap_out (h_wrap)
  );

  wrap_counter #(.MAX(TV), .W(V_W)) u_v_cnt (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .en_in    (h_wrap),
    .count_out(v_cnt),
    .wrap_out (v_wrap)
  );

  // Position the counters will hold after this edge (reset handled below).
  logic [H_W-1:0] h_la;
  logic [V_W-1:0] v_la;
  logic           nf_la;

  always_comb begin
    h_la  = run ? (h_wrap ? '0 : h_cnt + 1'b1) : '0;
    v_la  = h_wrap ? (v_wrap ? '0 : v_cnt + 1'b1) : v_cnt;
    nf_la = (h_la == H_ACT) && (v_la == V_ACT);
  end

  logic            h_sync_p0, v_sync_p0, active_p0, new_frame_p0;
  logic [FC_W-1:0] frame_cnt_p0;

  // Stage p0: flags registered alongside the counters
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      h_sync_p0    <= 1'b0;
      v_sync_p0    <= 1'b0;
      active_p0    <= 1'b0;
      new_frame_p0 <= 1'b0;
      frame_cnt_p0 <= '0;
    end else begin
      h_sync_p0    <= (h_la >= HS_LO) && (h_la <= HS_HI);
      v_sync_p0    <= (v_la >= VS_LO) && (v_la <= VS_HI);
      active_p0    <= (h_la < H_ACT) && (v_la < V_ACT);
      new_frame_p0 <= nf_la;
      if (nf_la) frame_cnt_p0 <= (frame_cnt_p0 == FC_LAST) ? '0 : frame_cnt_p0 + 1'b1;
    end
  end

  assign vid.h_count_out     = h_cnt;
  assign vid.v_count_out     = v_cnt;
  assign vid.h_sync_out      = h_sync_p0;
  assign vid.v_sync_out      = v_sync_p0;
  assign vid.active_draw_out = active_p0;
  assign vid.new_frame_out   = new_frame_p0;
  assign vid.frame_count_out = frame_cnt_p0;

`ifdef VSG_DATA_ISLAND_PREAMBLE_EN
  localparam logic [H_W-1:0] PRE_LO = H_W'(TH - 10);
  localparam logic [H_W-1:0] PRE_HI = H_W'(TH - 3);
  localparam logic [H_W-1:0] GRD_LO = H_W'(TH - 2);
  localparam logic [V_W-1:0] V_PRE_ACT = V_W'(ACTIVE_LINES - 1);
  localparam logic [V_W-1:0] V_LAST    = V_W'(TV - 1);

  logic next_line_active;
  logic preamble_p0, guard_p0;

  // Only lines whose successor is visible carry the preamble/guard.
  assign next_line_active = (v_la < V_PRE_ACT) || (v_la == V_LAST);

  // Stage p0: data-island markers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      preamble_p0 <= 1'b0;
      guard_p0    <= 1'b0;
    end else begin
      preamble_p0 <= next_line_active && (h_la >= PRE_LO) && (h_la <= PRE_HI);
      guard_p0    <= next_line_active && (h_la >= GRD_LO);
    end
  end

  assign vid.preamble_out = preamble_p0;
  assign vid.guard_out    = guard_p0;
`endif

endmodule

// File: tb/tb_video_sig_gen.sv
// Testbench for video_sig_gen on a reduced raster (28x17, 60 fps counter) so
// that many complete frames fit in a short run. A driver issues reset/run
// cycles and pushes the expected outputs for each edge into a scoreboard
// queue; a monitor pops and compares on every falling edge.
module tb_video_sig_gen;

  localparam int AH  = 16, HFP = 4, HSW = 3, HBP = 5;
  localparam int AL  = 10, VFP = 2, VSW = 2, VBP = 3;
  localparam int FPS = 60;
  localparam int TH  = AH + HFP + HSW + HBP;
  localparam int TV  = AL + VFP + VSW + VBP;
  localparam int FRAME = TH * TV;

  typedef struct {
    int h;
    int v;
    bit hs;
    bit vs;
    bit act;
    bit nf;
    int fc;
    bit pre;
    bit grd;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;

  video_sig_gen_if #(.FC_W(6)) vif ();

  video_sig_gen #(
    .ACTIVE_H_PIXELS(AH), .H_FRONT_PORCH(HFP), .H_SYNC_WIDTH(HSW), .H_BACK_PORCH(HBP),
    .ACTIVE_LINES(AL), .V_FRONT_PORCH(VFP), .V_SYNC_WIDTH(VSW), .V_BACK_PORCH(VBP),
    .FPS(FPS)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .vid   (vif.master)
  );

  always #5 clk_in = ~clk_in;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Reference model: raster position and frame count, advanced per edge.
  bit m_run = 0;
  int m_h = 0, m_v = 0, m_fc = 0;

  task automatic step(input bit r);
    exp_t e;
    rst_in = r;
    if (r) begin
      m_run = 0; m_h = 0; m_v = 0; m_fc = 0;
    end else if (!m_run) begin
      m_run = 1; m_h = 0; m_v = 0;
    end else begin
      m_h = m_h + 1;
      if (m_h == TH) begin
        m_h = 0;
        m_v = (m_v + 1) % TV;
      end
      if (m_h == AH && m_v == AL) m_fc = (m_fc + 1) % FPS;
    end
    e.h   = m_h;
    e.v   = m_v;
    e.hs  = m_run && (m_h >= AH + HFP) && (m_h < AH + HFP + HSW);
    e.vs  = m_run && (m_v >= AL + VFP) && (m_v < AL + VFP + VSW);
    e.act = m_run && (m_h < AH) && (m_v < AL);
    e.nf  = m_run && (m_h == AH) && (m_v == AL);
    e.fc  = m_fc;
    e.pre = m_run && (m_v < AL - 1 || m_v == TV - 1) && (m_h >= TH - 10) && (m_h <= TH - 3);
    e.grd = m_run && (m_v < AL - 1 || m_v == TV - 1) && (m_h >= TH - 2);
    sb_q.push_back(e);
    @(posedge clk_in);
    #1;
  endtask

  // Monitor: one comparison per presented cycle.
  always @(negedge clk_in) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      bit   ok;
      bit   a_pre, a_grd;
      e = sb_q.pop_front();
      cyc++;
`ifdef VSG_DATA_ISLAND_PREAMBLE_EN
      a_pre = vif.preamble_out;
      a_grd = vif.guard_out;
`else
      a_pre = e.pre;
      a_grd = e.grd;
`endif
      ok = (int'(vif.h_count_out) == e.h) && (int'(vif.v_count_out) == e.v) &&
           (vif.h_sync_out == e.hs) && (vif.v_sync_out == e.vs) &&
           (vif.active_draw_out == e.act) && (vif.new_frame_out == e.nf) &&
           (int'(vif.frame_count_out) == e.fc) && (a_pre == e.pre) && (a_grd == e.grd);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL raster cycle=%0d got h=%0d v=%0d hs=%0b vs=%0b act=%0b nf=%0b fc=%0d pre=%0b grd=%0b want h=%0d v=%0d hs=%0b vs=%0b act=%0b nf=%0b fc=%0d pre=%0b grd=%0b",
                 cyc, vif.h_count_out, vif.v_count_out, vif.h_sync_out, vif.v_sync_out,
                 vif.active_draw_out, vif.new_frame_out, vif.frame_count_out, a_pre, a_grd,
                 e.h, e.v, e.hs, e.vs, e.act, e.nf, e.fc, e.pre, e.grd);
      end
    end
  end

  initial begin
    int n;
    int guard_cnt;
    // Reset held, then more than FPS frames so the frame counter wraps.
    for (int i = 0; i < 5; i++) step(1'b1);
    for (int i = 0; i < (FPS + 1) * FRAME + 40; i++) step(1'b0);

    // Directed mid-frame reset at a visible pixel.
    guard_cnt = 0;
    while (!(m_h == 11 && m_v == 6) && guard_cnt < 2 * FRAME) begin
      step(1'b0);
      guard_cnt++;
    end
    step(1'b1);
    for (int i = 0; i < FRAME + 20; i++) step(1'b0);

    // Random run lengths interleaved with short random resets.
    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(2 * FRAME, 1);
      for (int i = 0; i < n; i++) step(1'b0);
      n = $urandom_range(3, 1);
      for (int i = 0; i < n; i++) step(1'b1);
    end
    for (int i = 0; i < FRAME; i++) step(1'b0);

    // Let the monitor drain the last expectations.
    guard_cnt = 0;
    while (sb_q.size() != 0 && guard_cnt < 10) begin
      @(posedge clk_in);
      guard_cnt++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
